router_fsm: RTL and testbench
=============================

ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  synchronous, active-high reset.
REQ-003: pkt_valid  input  1  high while a packet (header through last payload byte) is on the input bus.
REQ-004: data_in  input  2  destination address field of the header byte (0, 1, 2 valid; 3 invalid).
REQ-005: fifo_full  input  1  full flag of the currently addressed output FIFO, from the synchronizer.
REQ-006: fifo_empty_0 / fifo_empty_1 / fifo_empty_2  input  1 each  empty flags of output FIFOs 0..2.
REQ-007: soft_reset_0 / soft_reset_1 / soft_reset_2  input  1 each  per-FIFO soft reset from the synchronizer timeout.
REQ-008: parity_done  input  1  register block has latched the parity byte.
REQ-009: low_pkt_valid  input  1  register block saw pkt_valid fall while the FSM was stalled.
REQ-010: detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_en_reg, busy  output  1 each  state decodes (see Function).

Function
REQ-011: Eight states: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR.
REQ-012: The block has a 2-bit addr register, loaded from data_in on each clock where state=DECODE_ADDRESS, pkt_valid=1 and data_in!=3; it holds otherwise.
REQ-013: DECODE_ADDRESS transitions:
- pkt_valid=1, data_in=N (N in 0..2), fifo_empty_N=1 -> LOAD_FIRST_DATA.
- pkt_valid=1, data_in=N, fifo_empty_N=0 -> WAIT_TILL_EMPTY.
- data_in=3, or pkt_valid=0 -> stay.
REQ-014: WAIT_TILL_EMPTY transitions:
- fifo_empty[addr]=1 -> LOAD_FIRST_DATA.
- Otherwise stay.
REQ-015: LOAD_FIRST_DATA -> LOAD_DATA unconditionally, after one cycle.
REQ-016: LOAD_DATA transitions:
- fifo_full=1 -> FIFO_FULL_STATE.
- fifo_full=0 and pkt_valid=0 -> LOAD_PARITY.
- Otherwise stay.
- fifo_full has priority.
REQ-017: FIFO_FULL_STATE transitions:
- fifo_full=0 -> LOAD_AFTER_FULL.
- Otherwise stay.
REQ-018: LOAD_AFTER_FULL transitions:
- parity_done=1 -> DECODE_ADDRESS.
- parity_done=0, low_pkt_valid=1 -> LOAD_PARITY.
- parity_done=0, low_pkt_valid=0 -> LOAD_DATA.
REQ-019: LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-020: CHECK_PARITY_ERROR transitions:
- fifo_full=1 -> FIFO_FULL_STATE.
- Otherwise -> DECODE_ADDRESS.
REQ-021: When soft_reset_N=1 and addr=N, the next state is DECODE_ADDRESS from any state; this overrides REQ-013..020.
REQ-022: rst overrides soft reset.
REQ-023: Outputs are Moore, decoded from the current state only, with no combinational path from inputs:
- detect_add = DECODE_ADDRESS.
- lfd_state = LOAD_FIRST_DATA.
- ld_state = LOAD_DATA.
- laf_state = LOAD_AFTER_FULL.
- full_state = FIFO_FULL_STATE.
- rst_int_reg = CHECK_PARITY_ERROR.
REQ-024: write_en_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
REQ-025: busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
REQ-026: Exactly one of detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg is high in those six states; all six are low in LOAD_PARITY and WAIT_TILL_EMPTY.
REQ-027: Soft reset of a non-addressed FIFO has no effect on state.

Reset
REQ-028: While rst=1 at a rising edge, the following apply on the next edge:
- state=DECODE_ADDRESS and addr=0.
- detect_add=1.
- busy, write_en_reg, lfd_state, ld_state, laf_state, full_state and rst_int_reg = 0.
REQ-029: rst asserted mid-packet (any state) returns the block to DECODE_ADDRESS in one cycle; no output pulse other than the reset values appears.
REQ-030: After rst deasserts, the FSM may accept a header on the very next edge.

Verification
REQ-031: Scenarios the bench shall cover:
- Normal packet: rst, then pkt_valid=1, data_in=1, fifo_empty_1=1 for one cycle, pkt_valid=1 for 4 cycles, then pkt_valid=0 -> state sequence DECODE, LFD, LD x4, LOAD_PARITY, CHECK_PARITY_ERROR, DECODE. write_en_reg is high for 5 cycles; busy is high in LFD, LOAD_PARITY and CHECK_PARITY_ERROR.
- Busy destination: data_in=2, fifo_empty_2=0 -> WAIT_TILL_EMPTY with busy=1. Raise fifo_empty_2=1 after 10 cycles -> LOAD_FIRST_DATA next cycle.
- Full stall: in LOAD_DATA, fifo_full=1 -> full_state=1, busy=1, write_en_reg=0. Drop fifo_full with parity_done=0, low_pkt_valid=0 -> LOAD_AFTER_FULL, then LOAD_DATA.
- Full with packet end: from FIFO_FULL_STATE, release with low_pkt_valid=1 -> LAF, LOAD_PARITY, CHECK_PARITY_ERROR. Repeat with parity_done=1 -> LAF, then DECODE_ADDRESS.
- Soft reset: addr=0, state LOAD_DATA, soft_reset_1=1 -> no change. soft_reset_0=1 -> detect_add=1 next cycle.
- Invalid address and reset: data_in=3, pkt_valid=1 -> stays DECODE_ADDRESS with addr unchanged. rst=1 in FIFO_FULL_STATE -> DECODE_ADDRESS next edge.

Source files
------------

// File: rtl/router_fsm_if.sv
// Signal bundle between the router input side (header/payload stream, FIFO
// status, register-block flags) and the router control FSM.
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       write_en_reg;
    logic       busy;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state,
        input  full_state, rst_int_reg, write_en_reg, busy
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state,
        output full_state, rst_int_reg, write_en_reg, busy
    );
endinterface

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header destination, sequences payload and
// parity loading, and stalls on full or busy output FIFOs.
module router_fsm (
    input logic         clk,
    input logic         rst,
    router_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [1:0] addr_r;
    logic [7:0] outs_r;
    logic [2:0] fifo_empty_s;
    logic [2:0] soft_reset_s;
    logic       hdr_ok_s;
    logic       soft_hit_s;

    // Per-FIFO flag select; address 3 never names a FIFO.
    function automatic logic sel3(input logic [2:0] vec, input logic [1:0] idx);
        logic bit_v;
        case (idx)
            2'd0:    bit_v = vec[0];
            2'd1:    bit_v = vec[1];
            2'd2:    bit_v = vec[2];
            default: bit_v = 1'b0;
        endcase
        return bit_v;
    endfunction

    // Output vector {detect_add, lfd, ld, laf, full, rst_int, write_en, busy}.
    function automatic logic [7:0] decode_outs(input state_t st);
        logic [7:0] o_v;
        case (st)
            DECODE_ADDRESS:     o_v = 8'b1000_0000;
            LOAD_FIRST_DATA:    o_v = 8'b0100_0001;
            LOAD_DATA:          o_v = 8'b0010_0010;
            LOAD_AFTER_FULL:    o_v = 8'b0001_0011;
            FIFO_FULL_STATE:    o_v = 8'b0000_1001;
            CHECK_PARITY_ERROR: o_v = 8'b0000_0101;
            LOAD_PARITY:        o_v = 8'b0000_0011;
            WAIT_TILL_EMPTY:    o_v = 8'b0000_0001;
            default:            o_v = 8'b1000_0000;
        endcase
        return o_v;
    endfunction

    assign fifo_empty_s = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    assign soft_reset_s = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    assign hdr_ok_s     = bus.pkt_valid && (bus.data_in != 2'd3);
    assign soft_hit_s   = sel3(soft_reset_s, addr_r);

    // Next-state selection; a soft reset of the addressed FIFO aborts the packet.
    always_comb begin
        state_nxt_s = state_r;
        if (soft_hit_s) begin
            state_nxt_s = DECODE_ADDRESS;
        end else begin
            case (state_r)
                DECODE_ADDRESS: begin
                    if (!hdr_ok_s)
                        state_nxt_s = DECODE_ADDRESS;
                    else if (sel3(fifo_empty_s, bus.data_in))
                        state_nxt_s = LOAD_FIRST_DATA;
                    else
                        state_nxt_s = WAIT_TILL_EMPTY;
                end
                WAIT_TILL_EMPTY: begin
                    if (sel3(fifo_empty_s, addr_r)) state_nxt_s = LOAD_FIRST_DATA;
                    else                            state_nxt_s = WAIT_TILL_EMPTY;
                end
                LOAD_FIRST_DATA: state_nxt_s = LOAD_DATA;
                LOAD_DATA: begin
                    if (bus.fifo_full)       state_nxt_s = FIFO_FULL_STATE;
                    else if (!bus.pkt_valid) state_nxt_s = LOAD_PARITY;
                    else                     state_nxt_s = LOAD_DATA;
                end
                FIFO_FULL_STATE: begin
                    if (bus.fifo_full) state_nxt_s = FIFO_FULL_STATE;
                    else               state_nxt_s = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (bus.parity_done)        state_nxt_s = DECODE_ADDRESS;
                    else if (bus.low_pkt_valid) state_nxt_s = LOAD_PARITY;
                    else                        state_nxt_s = LOAD_DATA;
                end
                LOAD_PARITY: state_nxt_s = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    if (bus.fifo_full) state_nxt_s = FIFO_FULL_STATE;
                    else               state_nxt_s = DECODE_ADDRESS;
                end
                default: state_nxt_s = DECODE_ADDRESS;
            endcase
        end
    end

    // State, destination address and output registers; outputs track the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= DECODE_ADDRESS;
            addr_r  <= 2'd0;
            outs_r  <= decode_outs(DECODE_ADDRESS);
        end else begin
            state_r <= state_nxt_s;
            outs_r  <= decode_outs(state_nxt_s);
            if ((state_r == DECODE_ADDRESS) && hdr_ok_s)
                addr_r <= bus.data_in;
            else
                addr_r <= addr_r;
        end
    end

    assign bus.detect_add   = outs_r[7];
    assign bus.lfd_state    = outs_r[6];
    assign bus.ld_state     = outs_r[5];
    assign bus.laf_state    = outs_r[4];
    assign bus.full_state   = outs_r[3];
    assign bus.rst_int_reg  = outs_r[2];
    assign bus.write_en_reg = outs_r[1];
    assign bus.busy         = outs_r[0];
endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: directed vector table, a hand-written
// busy-destination sequence, then random stimulus against a rule-level model.
module tb_router_fsm;
    logic       clk = 1'b0;
    logic       rst;
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] emp;
    logic [2:0] sr;
    logic       pd;
    logic       lpv;
    logic [7:0] dut_out;

    router_fsm_if bus();

    router_fsm dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.pkt_valid     = pv;
    assign bus.data_in       = din;
    assign bus.fifo_full     = full;
    assign bus.fifo_empty_0  = emp[0];
    assign bus.fifo_empty_1  = emp[1];
    assign bus.fifo_empty_2  = emp[2];
    assign bus.soft_reset_0  = sr[0];
    assign bus.soft_reset_1  = sr[1];
    assign bus.soft_reset_2  = sr[2];
    assign bus.parity_done   = pd;
    assign bus.low_pkt_valid = lpv;
    assign dut_out = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                      bus.full_state, bus.rst_int_reg, bus.write_en_reg, bus.busy};

    // Expected outputs {detect,lfd,ld,laf,full,rst_int,write_en,busy} per state
    localparam logic [7:0] O_DA   = 8'b1000_0000;
    localparam logic [7:0] O_LFD  = 8'b0100_0001;
    localparam logic [7:0] O_LD   = 8'b0010_0010;
    localparam logic [7:0] O_LAF  = 8'b0001_0011;
    localparam logic [7:0] O_FULL = 8'b0000_1001;
    localparam logic [7:0] O_CPE  = 8'b0000_0101;
    localparam logic [7:0] O_LP   = 8'b0000_0011;
    localparam logic [7:0] O_WTE  = 8'b0000_0001;

    localparam int M_DA = 0, M_LFD = 1, M_LD = 2, M_LP = 3;
    localparam int M_FULL = 4, M_LAF = 5, M_WTE = 6, M_CPE = 7;

    logic [7:0] out_of [8];
    int m_st;
    int m_addr;
    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic       r;
        logic       pv;
        logic [1:0] din;
        logic       full;
        logic [2:0] emp;
        logic [2:0] sr;
        logic       pd;
        logic       lpv;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic p, input logic [1:0] d,
                                input logic f, input logic [2:0] e, input logic [2:0] s,
                                input logic pdn, input logic lp, input logic [7:0] x);
        vec_t v;
        v.r = r; v.pv = p; v.din = d; v.full = f; v.emp = e; v.sr = s;
        v.pd = pdn; v.lpv = lp; v.exp = x;
        return v;
    endfunction

    // Apply one clock edge to the reference model using the inputs now driven.
    task automatic model_edge();
        int nx;
        if (rst) begin
            m_st   = M_DA;
            m_addr = 0;
        end else begin
            if (sr[m_addr]) nx = M_DA;
            else if (m_st == M_DA)
                nx = (pv && din != 2'd3) ? (emp[din] ? M_LFD : M_WTE) : M_DA;
            else if (m_st == M_WTE) nx = emp[m_addr] ? M_LFD : M_WTE;
            else if (m_st == M_LFD) nx = M_LD;
            else if (m_st == M_LD)  nx = full ? M_FULL : (pv ? M_LD : M_LP);
            else if (m_st == M_FULL) nx = full ? M_FULL : M_LAF;
            else if (m_st == M_LAF) nx = pd ? M_DA : (lpv ? M_LP : M_LD);
            else if (m_st == M_LP)  nx = M_CPE;
            else                    nx = full ? M_FULL : M_DA;
            if (m_st == M_DA && pv && din != 2'd3) m_addr = int'(din);
            m_st = nx;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        compared++;
        if (dut_out !== exp) begin
            mismatched++;
            $display("FAIL %s: outputs got %b expected %b", name, dut_out, exp);
        end
    endtask

    task automatic drive(input logic r, input logic p, input logic [1:0] d, input logic f,
                         input logic [2:0] e, input logic [2:0] s, input logic pdn,
                         input logic lp);
        rst = r; pv = p; din = d; full = f; emp = e; sr = s; pd = pdn; lpv = lp;
    endtask

    initial begin
        out_of[M_DA] = O_DA;   out_of[M_LFD] = O_LFD; out_of[M_LD] = O_LD;
        out_of[M_LP] = O_LP;   out_of[M_FULL] = O_FULL; out_of[M_LAF] = O_LAF;
        out_of[M_WTE] = O_WTE; out_of[M_CPE] = O_CPE;
        m_st = M_DA;
        m_addr = 0;
        drive(1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);

        // Normal packet to FIFO 1
        tbl.push_back(mk(1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, O_DA));
        tbl.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, O_LFD));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, O_LD));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, O_LP));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, O_CPE));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, O_DA));
        // Full stall and resume into LOAD_DATA
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LFD));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, O_FULL));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, O_FULL));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LAF));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD));
        // Full with packet end (low_pkt_valid)
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, O_FULL));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, O_LAF));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1, O_LP));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_CPE));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_DA));
        // Full with parity already latched
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LFD));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, O_FULL));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, O_LAF));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, O_DA));
        // Parity check seeing a full FIFO
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LFD));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LP));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_CPE));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, O_FULL));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LAF));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, O_DA));
        // Soft reset: other FIFO ignored, addressed FIFO aborts
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LFD));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b010, 1'b0, 1'b0, O_LD));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b001, 1'b0, 1'b0, O_DA));
        // Invalid address holds in decode
        tbl.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_DA));
        tbl.push_back(mk(1'b0, 1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_DA));
        // Reset mid-stall, then header on the very next edge
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LFD));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD));
        tbl.push_back(mk(1'b0, 1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, O_FULL));
        tbl.push_back(mk(1'b1, 1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, O_DA));
        tbl.push_back(mk(1'b0, 1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LFD));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LD));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_LP));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_CPE));
        tbl.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0, O_DA));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].pv, tbl[i].din, tbl[i].full, tbl[i].emp,
                  tbl[i].sr, tbl[i].pd, tbl[i].lpv);
            tick();
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Busy destination: wait on FIFO 2, ignoring FIFO 0's soft reset meanwhile
        drive(1'b0, 1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
        tick();
        check("wte_enter", O_WTE);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 2'd0, 1'b0, 3'b011, (i == 4) ? 3'b001 : 3'b000, 1'b0, 1'b0);
            tick();
            check($sformatf("wte_hold%0d", i), O_WTE);
        end
        drive(1'b0, 1'b0, 2'd0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0);
        tick();
        check("wte_release", O_LFD);
        tick();
        check("wte_ld", O_LD);
        tick();
        check("wte_lp", O_LP);
        tick();
        check("wte_cpe", O_CPE);
        tick();
        check("wte_done", O_DA);

        // Random stimulus against the reference model
        for (int n = 0; n < 2000; n++) begin
            rst  = ($urandom_range(0, 49) == 0);
            pv   = ($urandom_range(0, 3) != 0);
            din  = 2'($urandom_range(0, 3));
            full = ($urandom_range(0, 3) == 0);
            emp  = 3'($urandom_range(0, 7));
            sr   = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 15) == 0)};
            pd   = ($urandom_range(0, 3) == 0);
            lpv  = ($urandom_range(0, 3) == 0);
            tick();
            check($sformatf("rand%0d", n), out_of[m_st]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
